// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: op codes, FSM states and op classification.
// Rotate support is controlled by the SHREG_ROTATE_EN macro.
package shreg_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ASR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for ops that walk through RUN one bit per step; everything else is a HOLD.
    function automatic logic is_step_op(input op_e op);
        logic w_res;
        w_res = 1'b0;
        case (op)
            OP_SHL, OP_SHR, OP_ASR: w_res = 1'b1;
`ifdef SHREG_ROTATE_EN
            OP_ROL, OP_ROR:         w_res = 1'b1;
`endif
            default:                w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-bit step network: next register value and the bit pushed out.
// Rotate paths exist only when SHREG_ROTATE_EN is defined.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_out,
    input  op_e              i_op,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    output logic [WIDTH-1:0] o_next,
    output logic             o_bit
);

    always_comb begin
        o_next = i_out;
        o_bit  = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_next = {i_out[WIDTH-2:0], i_sin_l};
                o_bit  = i_out[WIDTH-1];
            end
            OP_SHR: begin
                o_next = {i_sin_r, i_out[WIDTH-1:1]};
                o_bit  = i_out[0];
            end
            OP_ASR: begin
                o_next = {i_out[WIDTH-1], i_out[WIDTH-1:1]};
                o_bit  = i_out[0];
            end
`ifdef SHREG_ROTATE_EN
            OP_ROL: begin
                o_next = {i_out[WIDTH-2:0], i_out[WIDTH-1]};
                o_bit  = i_out[WIDTH-1];
            end
            OP_ROR: begin
                o_next = {i_out[0], i_out[WIDTH-1:1]};
                o_bit  = i_out[0];
            end
`endif
            default: begin
                o_next = i_out;
                o_bit  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-mode shift engine: load / shift / arithmetic shift / rotate by 0..WIDTH-1, one bit per enabled clock.
// Rotate ops (5/6) are built only with SHREG_ROTATE_EN; otherwise they complete as HOLD.
module universal_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   din_par,
    input  logic               sin_l,
    input  logic               sin_r,
    output logic [WIDTH-1:0]   out,
    output logic               sout,
    output logic               busy,
    output logic               done
);

    // Handshake: start is sampled only in IDLE on an edge where en=1; once accepted the
    // engine reports busy until IDLE is re-entered, and done is a one-cycle strobe
    // (stretched only by en=0) marking completion. There is no request queue.

    state_e               r_state;
    state_e               w_state_nxt;
    op_e                  r_op;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_out;
    logic                 r_sout;

    op_e                  w_op_in;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_arm;
    logic                 w_step;
    logic                 w_last;
    logic [WIDTH-1:0]     w_next;
    logic                 w_bit;

    assign w_op_in = op_e'(op);
    assign w_last  = (r_cnt == SHAMT_W'(1));

    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_out   (r_out),
        .i_op    (r_op),
        .i_sin_l (sin_l),
        .i_sin_r (sin_r),
        .o_next  (w_next),
        .o_bit   (w_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_arm       = 1'b0;
        w_step      = 1'b0;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (en && start) begin
                    w_accept = 1'b1;
                    if (w_op_in == OP_LOAD) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (is_step_op(w_op_in) && (amt != '0)) begin
                        w_arm       = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op   <= OP_HOLD;
            r_cnt  <= '0;
            r_out  <= '0;
            r_sout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= w_op_in;
            end
            if (w_load) begin
                r_out <= din_par;
            end
            if (w_arm) begin
                r_cnt <= amt;
            end
            if (w_step) begin
                r_out  <= w_next;
                r_sout <= w_bit;
                r_cnt  <= r_cnt - SHAMT_W'(1);
            end
        end
    end

    assign out  = r_out;
    assign sout = r_sout;

    a_run_cnt_nonzero: assert property (@(posedge clk) disable iff (!rstn)
        (r_state == ST_RUN) |-> (r_cnt != '0));

    a_done_implies_busy: assert property (@(posedge clk) disable iff (!rstn)
        done |-> busy);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: vector table, hand-written corner sequences,
// and randomized ops against an arithmetic reference model (honours SHREG_ROTATE_EN).
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int AW = 3;

`ifdef SHREG_ROTATE_EN
    localparam logic [W-1:0] ROT_OUT  = 8'h03;
    localparam logic         ROT_SOUT = 1'b1;
    localparam int           ROT_LAT  = 1;
`else
    localparam logic [W-1:0] ROT_OUT  = 8'h81;
    localparam logic         ROT_SOUT = 1'b0;
    localparam int           ROT_LAT  = 0;
`endif

    logic          clk;
    logic          rstn;
    logic          en;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  din_par;
    logic          sin_l;
    logic          sin_r;
    logic [W-1:0]  out;
    logic          sout;
    logic          busy;
    logic          done;

    int n_checks;
    int n_pass;

    logic [W-1:0] m_out;
    logic         m_sout;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .din_par (din_par),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .out     (out),
        .sout    (sout),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: whole operation computed arithmetically from the op definition.
    task automatic model(input int o, input int n, input logic [W-1:0] d,
                         input logic sl, input logic sr, output int lat);
        logic signed [W-1:0] s;
        logic [W-1:0] r;
        logic [2*W-1:0] wide;
        bit rot;
`ifdef SHREG_ROTATE_EN
        rot = 1'b1;
`else
        rot = 1'b0;
`endif
        lat = 0;
        if (o == 1) begin
            m_out = d;
        end else if (n == 0 || o == 0 || o == 7 || ((o == 5 || o == 6) && !rot)) begin
            lat = 0;
        end else begin
            lat = n;
            case (o)
                2: begin
                    wide   = {{W{1'b0}}, m_out} << n;
                    r      = wide[W-1:0] | (sl ? W'((1 << n) - 1) : '0);
                    m_sout = m_out[W-n];
                    m_out  = r;
                end
                3: begin
                    r      = (m_out >> n) | (sr ? W'(8'hFF << (W - n)) : '0);
                    m_sout = m_out[n-1];
                    m_out  = r;
                end
                4: begin
                    s      = m_out;
                    r      = s >>> n;
                    m_sout = m_out[n-1];
                    m_out  = r;
                end
                5: begin
                    r      = (m_out << n) | (m_out >> (W - n));
                    m_sout = r[0];
                    m_out  = r;
                end
                default: begin
                    r      = (m_out >> n) | (m_out << (W - n));
                    m_sout = r[W-1];
                    m_out  = r;
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op, waits (bounded) for done, returns observed latency in edges after accept.
    task automatic run_op(input int o, input int n, input logic [W-1:0] d,
                          input logic sl, input logic sr, output int lat);
        @(negedge clk);
        en      = 1'b1;
        start   = 1'b1;
        op      = 3'(o);
        amt     = AW'(n);
        din_par = d;
        sin_l   = sl;
        sin_r   = sr;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic after_done(input string tag);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        int           o;
        int           n;
        logic [W-1:0] d;
        logic         sl;
        logic         sr;
        logic [W-1:0] exp_out;
        logic         exp_sout;
        int           exp_lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat;
        int elat;
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{1, 0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 0};
        vecs[1]  = '{1, 0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 0};
        vecs[2]  = '{2, 3, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b0, 3};
        vecs[3]  = '{1, 0, 8'h90, 1'b0, 1'b0, 8'h90, 1'b0, 0};
        vecs[4]  = '{4, 2, 8'h00, 1'b0, 1'b1, 8'hE4, 1'b0, 2};
        vecs[5]  = '{1, 0, 8'h90, 1'b0, 1'b0, 8'h90, 1'b0, 0};
        vecs[6]  = '{3, 2, 8'h00, 1'b0, 1'b0, 8'h24, 1'b0, 2};
        vecs[7]  = '{1, 0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 0};
        vecs[8]  = '{5, 1, 8'h00, 1'b0, 1'b0, ROT_OUT, ROT_SOUT, ROT_LAT};
        vecs[9]  = '{0, 5, 8'hFF, 1'b1, 1'b1, ROT_OUT, ROT_SOUT, 0};
        vecs[10] = '{7, 3, 8'hFF, 1'b1, 1'b1, ROT_OUT, ROT_SOUT, 0};
        vecs[11] = '{3, 0, 8'hFF, 1'b1, 1'b1, ROT_OUT, ROT_SOUT, 0};
        vecs[12] = '{1, 0, 8'h01, 1'b0, 1'b0, 8'h01, ROT_SOUT, 0};
        vecs[13] = '{3, 1, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 1};
        vecs[14] = '{2, 7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 7};

        rstn = 1'b0; en = 1'b0; start = 1'b0; op = '0; amt = '0;
        din_par = '0; sin_l = 1'b0; sin_r = 1'b0;
        #12;
        check("rst_out",  {24'd0, out}, 32'd0);
        check("rst_sout", {31'd0, sout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ---- vector table ----
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].o, vecs[i].n, vecs[i].d, vecs[i].sl, vecs[i].sr, lat);
            check($sformatf("vec%0d_out", i),  {24'd0, out}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_sout", i), {31'd0, sout}, {31'd0, vecs[i].exp_sout});
            check($sformatf("vec%0d_lat", i),  lat, vecs[i].exp_lat);
            after_done($sformatf("vec%0d", i));
        end

        // ---- stall in RUN and start while busy ----
        run_op(1, 0, 8'h3C, 1'b0, 1'b0, lat);
        after_done("stall_load");
        @(negedge clk);
        en = 1'b1; start = 1'b1; op = 3'd2; amt = 3'd3; sin_l = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("stall_step1", {24'd0, out}, 32'h78);
        @(negedge clk);
        en = 1'b0; op = 3'd1; din_par = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("stall_frozen_out", {24'd0, out}, 32'h78);
            check("stall_no_done", {31'd0, done}, 32'd0);
            check("stall_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 check("stall_step2", {24'd0, out}, 32'hF0);
        check("stall_done_early", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 check("stall_step3", {24'd0, out}, 32'hE0);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_sout", {31'd0, sout}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        check("ignore_busy", {31'd0, busy}, 32'd0);
        check("ignore_out", {24'd0, out}, 32'hE0);

        // ---- serial input sampled on every step ----
        run_op(1, 0, 8'h00, 1'b0, 1'b0, lat);
        after_done("ser_load");
        @(negedge clk);
        start = 1'b1; op = 3'd2; amt = 3'd3; sin_l = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk) sin_l = 1'b1;
        @(negedge clk) sin_l = 1'b0;
        @(negedge clk) sin_l = 1'b1;
        @(posedge clk);
        #1 check("ser_out", {24'd0, out}, 32'h05);
        check("ser_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;

        // ---- asynchronous reset mid-RUN ----
        run_op(1, 0, 8'h55, 1'b0, 1'b0, lat);
        after_done("arst_load");
        @(negedge clk);
        start = 1'b1; op = 3'd3; amt = 3'd6; sin_r = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_out",  {24'd0, out}, 32'd0);
        check("arst_sout", {31'd0, sout}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ---- randomized ops vs reference model ----
        m_out  = '0;
        m_sout = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int o, n;
            logic [W-1:0] d;
            logic sl, sr;
            o  = $urandom_range(0, 7);
            n  = $urandom_range(0, W - 1);
            d  = W'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            if (i < 4) o = 1;
            model(o, n, d, sl, sr, elat);
            run_op(o, n, d, sl, sr, lat);
            check($sformatf("rnd%0d_op%0d_n%0d_out", i, o, n), {24'd0, out}, {24'd0, m_out});
            check($sformatf("rnd%0d_op%0d_n%0d_sout", i, o, n), {31'd0, sout}, {31'd0, m_sout});
            check($sformatf("rnd%0d_op%0d_n%0d_lat", i, o, n), lat, elat);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
